mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mips150_pkg.sv | 29 ++
 rtl/perf_counters.sv | 24 ++
 rtl/mem_io_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_io_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips150_pkg.sv
// Shared memory-map constants for the mips150 datapath: region decode and IO register offsets.
package mips150_pkg;

    localparam logic [3:0] IoRegionTag = 4'b1000;

    localparam logic [7:0] IoTxCtrl   = 8'h00;
    localparam logic [7:0] IoRxCtrl   = 8'h04;
    localparam logic [7:0] IoTxData   = 8'h08;
    localparam logic [7:0] IoRxData   = 8'h0C;
    localparam logic [7:0] IoCycleCnt = 8'h10;
    localparam logic [7:0] IoInstrCnt = 8'h14;
    localparam logic [7:0] IoCntClear = 8'h18;

    typedef struct packed {
        logic dmem;
        logic imem;
        logic io;
    } region_t;

    // DMEM and IMEM may both be selected for the same address.
    function automatic region_t decodeRegion(input logic [31:0] addr);
        region_t r;
        r.dmem = ~addr[31] & addr[28];
        r.imem = ~addr[31] & addr[29];
        r.io   = (addr[31:28] == IoRegionTag);
        return r;
    endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle counter and retired-instruction counter with a shared synchronous clear.
module perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        instrValid,
    input  logic        clear,
    output logic [31:0] cycleCount,
    output logic [31:0] instrCount
);

    // Clear wins over a same-cycle increment; both counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycleCount <= 32'h0;
            instrCount <= 32'h0;
        end else begin
            cycleCount <= cycleCount + 32'h1;
            if (instrValid) begin
                instrCount <= instrCount + 32'h1;
            end
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO controller: routes store masks to DMEM/IMEM, serves memory-mapped UART and counters.
module mem_io_ctrl
    import mips150_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  StoreMask,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  PCTop,
    input  logic        InstrValid,
    output logic [3:0]  StoreMaskDMEM,
    output logic [3:0]  StoreMaskIMEM,
    output logic        LoadDMEMorIO,
    output logic [31:0] DataFromIO,
    output logic [7:0]  UARTTxData,
    output logic        UARTTxValid,
    input  logic        UARTTxReady,
    input  logic [7:0]  UARTRxData,
    input  logic        UARTRxValid,
    output logic        UARTRxReady
);

    region_t     region;
    logic [7:0]  ioOffset;
    logic        ioWrite;
    logic        txWrite;
    logic        txFire;
    logic        rxPop;
    logic        rxAccept;
    logic        cntClear;
    logic [31:0] cycleCount;
    logic [31:0] instrCount;
    logic [31:0] ioReadData;

    logic        txPending, txPendingNext;
    logic [7:0]  txBuf, txBufNext;
    logic        rxFull, rxFullNext;
    logic [7:0]  rxBuf, rxBufNext;

    logic        unusedBits;
    assign unusedBits = ^{Addr[27:8], WData[31:8], PCTop[3], PCTop[1:0]};

    assign region   = decodeRegion(Addr);
    assign ioOffset = Addr[7:0];
    assign ioWrite  = region.io && (StoreMask != 4'b0000);
    assign txWrite  = ioWrite && (ioOffset == IoTxData);
    assign cntClear = ioWrite && (ioOffset == IoCntClear);
    assign txFire   = txPending && UARTTxReady;
    assign rxAccept = UARTRxValid && !rxFull;
    // A load from the RX data register consumes the byte; stores there do not.
    assign rxPop    = region.io && (StoreMask == 4'b0000) && (ioOffset == IoRxData);

    always_comb begin
        txPendingNext = txPending;
        txBufNext     = txBuf;
        // A write landing while a byte is pending (even on its final handshake cycle) is dropped.
        if (txFire) begin
            txPendingNext = 1'b0;
        end else if (txWrite && !txPending) begin
            txPendingNext = 1'b1;
            txBufNext     = WData[7:0];
        end
    end

    always_comb begin
        rxFullNext = rxFull;
        rxBufNext  = rxBuf;
        if (rxAccept) begin
            rxFullNext = 1'b1;
            rxBufNext  = UARTRxData;
        end else if (rxPop) begin
            rxFullNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txPending <= 1'b0;
            txBuf     <= 8'h00;
            rxFull    <= 1'b0;
            rxBuf     <= 8'h00;
        end else begin
            txPending <= txPendingNext;
            txBuf     <= txBufNext;
            rxFull    <= rxFullNext;
            rxBuf     <= rxBufNext;
        end
    end

    perf_counters uPerfCounters (
        .clk        (clk),
        .rst        (rst),
        .instrValid (InstrValid),
        .clear      (cntClear),
        .cycleCount (cycleCount),
        .instrCount (instrCount)
    );

    always_comb begin
        ioReadData = 32'h0;
        case (ioOffset)
            IoTxCtrl:   ioReadData = {31'h0, ~txPending};
            IoRxCtrl:   ioReadData = {31'h0, rxFull};
            IoRxData:   ioReadData = rxFull ? {24'h0, rxBuf} : 32'h0;
            IoCycleCnt: ioReadData = cycleCount;
            IoInstrCnt: ioReadData = instrCount;
            default:    ioReadData = 32'h0;
        endcase
    end

    assign StoreMaskDMEM = (!rst && region.dmem) ? StoreMask : 4'b0000;
    assign StoreMaskIMEM = (!rst && region.imem && PCTop[2]) ? StoreMask : 4'b0000;
    assign LoadDMEMorIO  = !rst && region.io;
    assign DataFromIO    = (!rst && region.io) ? ioReadData : 32'h0;
    assign UARTTxValid   = !rst && txPending;
    assign UARTTxData    = txBuf;
    assign UARTRxReady   = !rst && !rxFull;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_mem_io_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  StoreMask = 4'h0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] WData = 32'h0;
    logic [3:0]  PCTop = 4'h0;
    logic        InstrValid = 1'b0;
    logic [3:0]  StoreMaskDMEM;
    logic [3:0]  StoreMaskIMEM;
    logic        LoadDMEMorIO;
    logic [31:0] DataFromIO;
    logic [7:0]  UARTTxData;
    logic        UARTTxValid;
    logic        UARTTxReady = 1'b0;
    logic [7:0]  UARTRxData = 8'h0;
    logic        UARTRxValid = 1'b0;
    logic        UARTRxReady;

    mem_io_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .StoreMask     (StoreMask),
        .Addr          (Addr),
        .WData         (WData),
        .PCTop         (PCTop),
        .InstrValid    (InstrValid),
        .StoreMaskDMEM (StoreMaskDMEM),
        .StoreMaskIMEM (StoreMaskIMEM),
        .LoadDMEMorIO  (LoadDMEMorIO),
        .DataFromIO    (DataFromIO),
        .UARTTxData    (UARTTxData),
        .UARTTxValid   (UARTTxValid),
        .UARTTxReady   (UARTTxReady),
        .UARTRxData    (UARTRxData),
        .UARTRxValid   (UARTRxValid),
        .UARTRxReady   (UARTRxReady)
    );

    always #5 clk = ~clk;

    localparam int unsigned SelDmem   = 0;
    localparam int unsigned SelImem   = 1;
    localparam int unsigned SelLoadIo = 2;
    localparam int unsigned SelData   = 3;
    localparam int unsigned SelTxV    = 4;
    localparam int unsigned SelTxD    = 5;
    localparam int unsigned SelRxRdy  = 6;
    localparam int unsigned SelTxLeft = 7;

    typedef struct {
        string       name;
        int unsigned sel;
        logic [31:0] want;
    } chk_t;

    chk_t       chkQ[$];
    logic [7:0] txQ[$];
    int         errors = 0;
    int         checks = 0;

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            SelDmem:   return {28'h0, StoreMaskDMEM};
            SelImem:   return {28'h0, StoreMaskIMEM};
            SelLoadIo: return {31'h0, LoadDMEMorIO};
            SelData:   return DataFromIO;
            SelTxV:    return {31'h0, UARTTxValid};
            SelTxD:    return {24'h0, UARTTxData};
            SelRxRdy:  return {31'h0, UARTRxReady};
            SelTxLeft: return 32'(txQ.size());
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input int unsigned sel, input logic [31:0] want);
        chkQ.push_back('{name, sel, want});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drains expectations queued this cycle and checks every TX handshake.
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [31:0] got;
        logic [7:0]  wantByte;
        while (chkQ.size() != 0) begin
            c   = chkQ.pop_front();
            got = observe(c.sel);
            checks++;
            if (got !== c.want) begin
                errors++;
                $display("FAIL %s: got %h, want %h", c.name, got, c.want);
            end
        end
        if (UARTTxValid && UARTTxReady) begin
            checks++;
            if (txQ.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h, want no byte", UARTTxData);
            end else begin
                wantByte = txQ.pop_front();
                if (UARTTxData !== wantByte) begin
                    errors++;
                    $display("FAIL tx_byte: got %h, want %h", UARTTxData, wantByte);
                end
            end
        end
    end

    initial begin
        // Reset: outputs forced low even with store/IO addresses applied.
        cyc();
        Addr = 32'h3000_0000; StoreMask = 4'hF; PCTop = 4'h4;
        chk("rst_dmem", SelDmem, 32'h0);
        chk("rst_imem", SelImem, 32'h0);
        cyc();
        Addr = 32'h8000_0010; StoreMask = 4'h0; PCTop = 4'h0;
        chk("rst_data", SelData, 32'h0);
        chk("rst_loadio", SelLoadIo, 32'h0);
        chk("rst_txvalid", SelTxV, 32'h0);
        chk("rst_rxready", SelRxRdy, 32'h0);
        cyc();
        rst = 1'b0;
        Addr = 32'h0;

        // Counters: 20 cycles, InstrValid on 10 of them.
        for (int i = 0; i < 20; i++) begin
            InstrValid = (i % 2) == 1;
            if (i == 0) begin
                chk("post_rst_rxready", SelRxRdy, 32'h1);
                chk("post_rst_txvalid", SelTxV, 32'h0);
            end
            cyc();
        end
        InstrValid = 1'b0;
        Addr = 32'h8000_0010; chk("cycle_cnt_20", SelData, 32'd20); cyc();
        Addr = 32'h8000_0014; chk("instr_cnt_10", SelData, 32'd10); cyc();
        Addr = 32'h8000_0018; StoreMask = 4'hF; InstrValid = 1'b1;
        chk("clear_loadio", SelLoadIo, 32'h1);
        cyc();
        StoreMask = 4'h0; InstrValid = 1'b0;
        Addr = 32'h8000_0010; chk("cycle_cnt_clr", SelData, 32'h0); cyc();
        Addr = 32'h8000_0014; chk("instr_cnt_clr", SelData, 32'h0); cyc();

        // Region decode.
        Addr = 32'h1000_0010; StoreMask = 4'hF; PCTop = 4'h0;
        chk("sw_dmem", SelDmem, 32'hF);
        chk("sw_dmem_imem", SelImem, 32'h0);
        chk("sw_dmem_loadio", SelLoadIo, 32'h0);
        cyc();
        Addr = 32'h2000_0004; PCTop = 4'h4;
        chk("sw_imem", SelImem, 32'hF);
        chk("sw_imem_dmem", SelDmem, 32'h0);
        cyc();
        PCTop = 4'h0; chk("sw_imem_pc0", SelImem, 32'h0); cyc();
        Addr = 32'h3000_0000; StoreMask = 4'b0011; PCTop = 4'h4;
        chk("overlap_dmem", SelDmem, 32'h3);
        chk("overlap_imem", SelImem, 32'h3);
        cyc();
        Addr = 32'h9000_0000; StoreMask = 4'hF;
        chk("hi_dmem", SelDmem, 32'h0);
        chk("hi_imem", SelImem, 32'h0);
        chk("hi_loadio", SelLoadIo, 32'h0);
        cyc();
        PCTop = 4'h0;

        // TX: write held while not ready, second write dropped.
        Addr = 32'h8000_0008; StoreMask = 4'hF; WData = 32'h0000_0141;
        txQ.push_back(8'h41);
        chk("tx_wr_valid0", SelTxV, 32'h0);
        chk("tx_wo_read", SelData, 32'h0);
        cyc();
        StoreMask = 4'h0; Addr = 32'h8000_0000;
        chk("tx_valid", SelTxV, 32'h1);
        chk("tx_data", SelTxD, 32'h41);
        chk("tx_ctrl_busy", SelData, 32'h0);
        cyc();
        Addr = 32'h8000_0008; StoreMask = 4'hF; WData = 32'h42;
        chk("tx_hold_data", SelTxD, 32'h41);
        cyc();
        StoreMask = 4'h0; Addr = 32'h0;
        chk("tx_drop_valid", SelTxV, 32'h1);
        chk("tx_drop_data", SelTxD, 32'h41);
        cyc();
        UARTTxReady = 1'b1;
        chk("tx_fire_valid", SelTxV, 32'h1);
        cyc();
        UARTTxReady = 1'b0; Addr = 32'h8000_0000;
        chk("tx_done_valid", SelTxV, 32'h0);
        chk("tx_ctrl_idle", SelData, 32'h1);
        cyc();

        // TX write on the handshake cycle is dropped.
        Addr = 32'h8000_0008; StoreMask = 4'hF; WData = 32'h43;
        txQ.push_back(8'h43);
        cyc();
        UARTTxReady = 1'b1; WData = 32'h44;
        cyc();
        UARTTxReady = 1'b0; StoreMask = 4'h0; Addr = 32'h8000_0000;
        chk("tx_race_valid", SelTxV, 32'h0);
        chk("tx_race_ctrl", SelData, 32'h1);
        cyc();

        // RX capture, status, pop.
        Addr = 32'h0; UARTRxValid = 1'b1; UARTRxData = 8'h5A;
        chk("rx_ready_idle", SelRxRdy, 32'h1);
        cyc();
        UARTRxData = 8'h77; Addr = 32'h8000_0004;
        chk("rx_ready_full", SelRxRdy, 32'h0);
        chk("rx_ctrl_full", SelData, 32'h1);
        cyc();
        UARTRxValid = 1'b0; Addr = 32'h8000_000C;
        chk("rx_data", SelData, 32'h5A);
        chk("rx_loadio", SelLoadIo, 32'h1);
        cyc();
        Addr = 32'h8000_0004;
        chk("rx_ctrl_popped", SelData, 32'h0);
        chk("rx_ready_popped", SelRxRdy, 32'h1);
        cyc();
        Addr = 32'h8000_000C; chk("rx_pop_empty", SelData, 32'h0); cyc();
        Addr = 32'h0; UARTRxValid = 1'b1; UARTRxData = 8'h33; cyc();
        UARTRxValid = 1'b0; Addr = 32'h8000_000C; StoreMask = 4'hF;
        chk("rx_store_read", SelData, 32'h33);
        cyc();
        StoreMask = 4'h0; Addr = 32'h8000_0004;
        chk("rx_store_nopop", SelData, 32'h1);
        cyc();
        Addr = 32'h8000_000C; chk("rx_data2", SelData, 32'h33); cyc();
        Addr = 32'h8000_0020; chk("unmapped_read", SelData, 32'h0); cyc();
        Addr = 32'h8000_0018; chk("clr_reg_read", SelData, 32'h0); cyc();

        // Reset while TX pending and RX full discards both.
        Addr = 32'h8000_0008; StoreMask = 4'hF; WData = 32'h55; cyc();
        StoreMask = 4'h0; Addr = 32'h0; UARTRxValid = 1'b1; UARTRxData = 8'h66;
        chk("pre_rst_txvalid", SelTxV, 32'h1);
        cyc();
        UARTRxValid = 1'b0; Addr = 32'h8000_0004;
        chk("pre_rst_rxfull", SelData, 32'h1);
        cyc();
        rst = 1'b1; InstrValid = 1'b1;
        txQ.delete();
        chk("mid_rst_txvalid", SelTxV, 32'h0);
        chk("mid_rst_rxready", SelRxRdy, 32'h0);
        chk("mid_rst_loadio", SelLoadIo, 32'h0);
        chk("mid_rst_data", SelData, 32'h0);
        cyc();
        rst = 1'b0; InstrValid = 1'b0; Addr = 32'h8000_0010;
        chk("rel_cycle_cnt", SelData, 32'h0);
        chk("rel_txvalid", SelTxV, 32'h0);
        chk("rel_rxready", SelRxRdy, 32'h1);
        cyc();
        Addr = 32'h8000_0004; chk("rel_rx_ctrl", SelData, 32'h0); cyc();
        Addr = 32'h8000_0014; chk("rel_instr_cnt", SelData, 32'h0); cyc();
        Addr = 32'h8000_000C; chk("rel_rx_data", SelData, 32'h0); cyc();
        Addr = 32'h0;
        chk("tx_all_sent", SelTxLeft, 32'h0);
        cyc();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
